// File: rtl/sram22_param_sram.sv
`default_nettype none
// ============================================================================
// Module   : sram22_param_sram
// Purpose  : Parametrised behavioural SRAM model for the sram22 macro family.
//            Per-lane write mask, optional output pipeline register, read-valid
//            strobe and an optional post-reset clear sequencer.
// Ports    : clk        - clock, all state changes on rising edge
//            rst        - asynchronous active-high reset
//            ce         - chip enable
//            we         - 1 = write, 0 = read (when ce=1)
//            wmask      - per-lane write enable, lane i = din[i*LW +: LW]
//            addr       - word address
//            din        - write data
//            dout       - read data, held between reads
//            dout_valid - one-cycle strobe when dout presents new read data
//            ready      - array accepts accesses
// Config   : SRAM22_CLEAR_EN - when defined, zero-fills the array after every
//            reset and holds ready low for WORDS cycles.
// Revision : 1.0 - initial release
// ============================================================================
module sram22_param_sram #(
  parameter int WORDS       = 128,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4,
  parameter int ADDR_WIDTH  = $clog2(WORDS),
  parameter int OUT_REG     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   ready
);

  localparam int                  c_lane_w   = DATA_WIDTH / WMASK_WIDTH;
  localparam int                  c_last_int = WORDS - 1;
  localparam logic [ADDR_WIDTH:0] c_words    = WORDS[ADDR_WIDTH:0];

  // Illegal configurations stop elaboration.
  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_err_lane
    $error("sram22_param_sram: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (OUT_REG != 0 && OUT_REG != 1) begin : g_err_outreg
    $error("sram22_param_sram: OUT_REG must be 0 or 1");
  end
  if (WORDS < 2) begin : g_err_words
    $error("sram22_param_sram: WORDS must be at least 2");
  end
  if ((2 ** ADDR_WIDTH) < WORDS) begin : g_err_addr
    $error("sram22_param_sram: ADDR_WIDTH too small for WORDS");
  end

  logic                   w_acc;
  logic                   w_in_range;
  logic                   w_rd;
  logic [DATA_WIDTH-1:0]  w_rd_data;
  logic                   w_mem_we;
  logic [ADDR_WIDTH-1:0]  w_mem_addr;
  logic [DATA_WIDTH-1:0]  w_mem_wdata;
  logic [WMASK_WIDTH-1:0] w_mem_lanes;
  logic [DATA_WIDTH-1:0]  r_mem [WORDS];
  logic [DATA_WIDTH-1:0]  r_dout;
  logic                   r_dout_valid;

  assign w_acc      = ce & ready;
  // Zero-extend so the compare also works when WORDS == 2**ADDR_WIDTH.
  assign w_in_range = ({1'b0, addr} < c_words);
  assign w_rd       = w_acc & ~we;
  assign w_rd_data  = w_in_range ? r_mem[addr] : '0;

`ifdef SRAM22_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] c_last = c_last_int[ADDR_WIDTH-1:0];

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The clear sequencer owns the write port while CLEAR; user traffic is
  // already blocked there because ready is low.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = w_acc & we & w_in_range;
    w_mem_addr  = addr;
    w_mem_wdata = din;
    w_mem_lanes = wmask;
    if (r_state == CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_cnt;
      w_mem_wdata = '0;
      w_mem_lanes = '1;
      w_cnt_nxt   = r_cnt + 1'b1;
      if (r_cnt == c_last) begin
        w_state_nxt = IDLE;
      end
    end
  end

  assign ready = (r_state == IDLE);
`else
  always_comb begin
    w_mem_we    = w_acc & we & w_in_range;
    w_mem_addr  = addr;
    w_mem_wdata = din;
    w_mem_lanes = wmask;
  end

  assign ready = 1'b1;
`endif

  // Array is deliberately not reset; only the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (w_mem_lanes[i]) begin
          r_mem[w_mem_addr][i*c_lane_w +: c_lane_w] <= w_mem_wdata[i*c_lane_w +: c_lane_w];
        end
      end
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_s1_data;
      logic                  r_s1_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1_data    <= '0;
          r_s1_valid   <= 1'b0;
          r_dout       <= '0;
          r_dout_valid <= 1'b0;
        end else begin
          r_s1_valid   <= w_rd;
          if (w_rd) begin
            r_s1_data <= w_rd_data;
          end
          r_dout_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_dout <= r_s1_data;
          end
        end
      end
    end else begin : g_out_direct
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dout       <= '0;
          r_dout_valid <= 1'b0;
        end else begin
          r_dout_valid <= w_rd;
          if (w_rd) begin
            r_dout <= w_rd_data;
          end
        end
      end
    end
  endgenerate

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: doc/sram22_param_sram.md
# sram22_param_sram

Parametrised behavioural SRAM model for the sram22 macro family, generalising the fixed 128x32 byte-masked model to arbitrary depth, width and mask granularity. Adds an optional output pipeline register, a read-valid strobe and a post-reset clear sequencer that zero-fills the array before accepting traffic. It is the model instantiated by simulation and by digital wrappers for every generated sram22 macro configuration.

## Interface

Parameters:
- WORDS, 128, number of words; need not be a power of two.
- DATA_WIDTH, 32, bits per word.
- WMASK_WIDTH, 4, write-mask lanes; DATA_WIDTH % WMASK_WIDTH must be 0. Lane width is DATA_WIDTH/WMASK_WIDTH.
- ADDR_WIDTH, $clog2(WORDS), address bits; minimum 1.
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register for read latency 2.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ce  in  1  chip enable.
- we  in  1  write enable; 1 = write, 0 = read when ce=1.
- wmask  in  WMASK_WIDTH  per-lane write enable; bit i covers din[i*LW +: LW].
- addr  in  ADDR_WIDTH  word address.
- din  in  DATA_WIDTH  write data.
- dout  out  DATA_WIDTH  read data; holds its last value between reads.
- dout_valid  out  1  one-cycle strobe, high in the cycle dout presents new read data.
- ready  out  1  high when the array accepts accesses.

## Operation

- Access accepted on a rising edge when ce=1 and ready=1; otherwise ce/we/addr/din/wmask are ignored.
- Write (we=1): for each lane i with wmask[i]=1, mem[addr] lane i <= din lane i; other lanes unchanged. wmask=0 is a legal no-op. A write never changes dout or dout_valid.
- Read (we=0): mem[addr] captured; no mask applied.
- Out-of-range address (addr >= WORDS): write discarded; read returns all-zero data with dout_valid asserted normally.
- Back-to-back reads are accepted every cycle; the pipeline has no stalls.
- Write then read of the same address on consecutive cycles returns the newly written data.
- Clear sequencer states (SRAM22_CLEAR_EN defined): CLEAR, IDLE.
  - Reset forces CLEAR with counter 0.
  - In CLEAR, each cycle writes all-zero data to mem[counter] and increments; counter is ADDR_WIDTH bits.
  - After the write to WORDS-1, transition to IDLE; ready rises on the same edge.
  - IDLE is terminal until the next reset.
- Elaboration errors: DATA_WIDTH % WMASK_WIDTH != 0, OUT_REG not in {0,1}, WORDS < 2, or 2**ADDR_WIDTH < WORDS.

## Timing

- Reset values: dout=0, dout_valid=0, ready=0 with SRAM22_CLEAR_EN, ready=1 without; pipeline stages 0.
- Clear duration is exactly WORDS cycles after rst deasserts; ready is first high on edge WORDS after the first edge with rst=0.
- OUT_REG=0: read accepted at edge N gives dout/dout_valid updated at edge N, visible in cycle N+1.
- OUT_REG=1: read accepted at edge N gives dout/dout_valid updated at edge N+1.
- Reset mid-operation: in-flight reads are discarded (no dout_valid), dout returns to 0, and the clear restarts from address 0. Partial array contents are undefined until the clear completes.

## Configuration

- SRAM22_CLEAR_EN defined: clear sequencer compiled in; array zero after every reset; ready low for WORDS cycles.
- Not defined: no sequencer and no counter; ready is tied to 1 outside reset; array contents after reset are X in simulation (not initialised).

## Test plan

- Defaults, SRAM22_CLEAR_EN: release rst, count cycles -> ready rises after exactly 128 cycles; a read of any address then returns 0x00000000 with a one-cycle dout_valid.
- Masked write: write 0xAABBCCDD mask 0xF to addr 5, then write 0x11223344 mask 0b0101, then read -> 0xAA22CC44.
- OUT_REG=1: reads of addr 1,2,3 on consecutive cycles, holding 0x1,0x2,0x3 -> dout shows 0x1,0x2,0x3 on edges N+1..N+3, dout_valid high exactly 3 cycles.
- WORDS=100, DATA_WIDTH=18, WMASK_WIDTH=2: write addr 120 -> no array change; read addr 120 -> 0x00000 with dout_valid; read addr 99 after write 0x3FFFF -> 0x3FFFF.
- Reset mid-clear and mid-read: assert rst at clear counter 40, then again with one read in flight -> dout=0 immediately, no dout_valid, clear restarts and takes the full 128 cycles.
- ce=0 with we=1 and a valid addr, and ce=1 while ready=0 -> memory unchanged and dout_valid stays 0.
